// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO drain arbiter.
package fifo_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // clog2 that never returns 0, so derived index fields stay at least 1 bit wide
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping.
module rr_pick #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] last,
  output logic            any,
  output logic [CH_W-1:0] idx
);

  logic [2*N_CH-1:0] dbl;
  logic              found;

  // Doubled request vector: scanning upward from last+1 covers the wrap without a modulo
  always_comb begin
    dbl   = {req, req};
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 2 * N_CH; i++) begin
      if (!found && dbl[i] && (i > int'(last))) begin
        found = 1'b1;
        idx   = CH_W'((i >= N_CH) ? (i - N_CH) : i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains N_CH FWFT channel FIFOs round-robin, in bursts of up to MAX_BURST words,
// into one registered valid/ready stream tagged with the source channel.
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CH_W      = clog2_min1(N_CH),
  parameter int unsigned BURST_W   = clog2_min1(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH-1:0]           ch_enable,
  input  logic [N_CH-1:0]           fifo_empty,
  input  logic [N_CH*DATA_SIZE-1:0] fifo_data,
  output logic [N_CH-1:0]           fifo_read,
  output logic [DATA_SIZE-1:0]      out_data,
  output logic [CH_W-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH_W-1:0]           grant,
  output logic                      busy
);

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        grant_q, grant_d;
  logic [BURST_W-1:0]     cnt_q, cnt_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic [CH_W-1:0]        chan_q, chan_d;
  logic                   valid_q, valid_d;

  logic [N_CH-1:0]        req;
  logic                   pick_any;
  logic [CH_W-1:0]        pick_idx;
  logic                   g_avail;
  logic [DATA_SIZE-1:0]   g_data;
  logic                   pop;

  assign req = ch_enable & ~fifo_empty;

  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .req  (req),
    .last (grant_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    g_avail = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (CH_W'(i) == grant_q) begin
        g_avail = req[i];
        g_data  = fifo_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    chan_d    = chan_q;
    valid_d   = valid_q;
    fifo_read = '0;
    pop       = 1'b0;

    if (valid_q && out_ready) valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        // Reset gates the pop so no word leaves a channel FIFO while the output is being cleared
        pop = g_avail && (out_ready || !valid_q) && !reset;
        if (pop) begin
          fifo_read = N_CH'(1) << grant_q;
          data_d    = g_data;
          chan_d    = grant_q;
          valid_d   = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == BURST_W'(MAX_BURST - 1)) state_d = ST_IDLE;
        end else if (!g_avail) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= CH_W'(N_CH - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;
  assign grant     = grant_q;
  assign busy      = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench: FWFT channel FIFO models, burst-level round-robin reference, scoreboard.
module tb_fifo_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;
  localparam int unsigned CW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    ch_enable, fifo_empty, fifo_read;
  logic [N*DW-1:0] fifo_data;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_chan, grant;
  logic            out_valid, out_ready, busy;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(
    .N_CH      (N),
    .DATA_SIZE (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_enable  (ch_enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grant      (grant),
    .busy       (busy)
  );

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [DW-1:0] d;
  } word_t;

  typedef struct {
    logic [N-1:0]  en;
    logic [N-1:0]  ne;
    int unsigned   words;
    logic [CW-1:0] first;
    int unsigned   cyc;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] chq [N][$];
  word_t         expq[$];
  int unsigned   ready_mode;
  int unsigned   pops;
  int unsigned   tagc = 0;
  logic [N-1:0]  s_rd;
  logic          s_valid, s_busy;
  logic [CW-1:0] s_chan;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < int'(N); i++) begin
      fifo_empty[i]         = (chq[i].size() == 0);
      fifo_data[i*DW +: DW] = (chq[i].size() != 0) ? chq[i][0] : '0;
    end
  endtask

  task automatic load(input int unsigned ch, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) chq[ch].push_back({8'(ch), 8'(tagc), 16'(k)});
    tagc++;
    drive_fifos();
  endtask

  // Reference: serve requesting channels in RR order after 'start', min(MB, remaining) words each
  task automatic build_exp(input logic [N-1:0] en, input int unsigned start);
    int unsigned cnt [N];
    int unsigned pos [N];
    int unsigned g;
    int          found;
    int unsigned c, n;
    word_t       w;
    g = start;
    for (int i = 0; i < int'(N); i++) begin
      cnt[i] = chq[i].size();
      pos[i] = 0;
    end
    while (1) begin
      found = -1;
      for (int unsigned k = 1; k <= N; k++) begin
        c = (g + k) % N;
        if (found < 0 && en[c] && cnt[c] > 0) found = int'(c);
      end
      if (found < 0) break;
      g = int'(found);
      n = (cnt[g] < MB) ? cnt[g] : MB;
      for (int unsigned j = 0; j < n; j++) begin
        w.ch = CW'(g);
        w.d  = chq[g][pos[g]];
        expq.push_back(w);
        pos[g]++;
        cnt[g]--;
      end
    end
  endtask

  task automatic cycle();
    word_t w;
    @(negedge clk);
    s_rd    = fifo_read;
    s_valid = out_valid;
    s_chan  = out_chan;
    s_busy  = busy;
    check("rd_onehot0", 64'($onehot0(fifo_read)), 64'(1));
    check("rd_disabled", 64'(fifo_read & ~ch_enable), 64'(0));
    check("rd_empty", 64'(fifo_read & fifo_empty), 64'(0));
    if (out_valid && !out_ready) check("rd_stall", 64'(fifo_read), 64'(0));
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word got ch%0d data %h required none", out_chan, out_data);
      end else begin
        w = expq.pop_front();
        check("out_chan", 64'(out_chan), 64'(w.ch));
        check("out_data", 64'(out_data), 64'(w.d));
      end
    end
    pops += $countones(fifo_read);
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N); i++)
      if (s_rd[i] && chq[i].size() != 0) void'(chq[i].pop_front());
    drive_fifos();
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic drain(output int unsigned ncyc);
    ncyc = 0;
    while (expq.size() > 0 && ncyc < 2000) begin
      cycle();
      ncyc++;
    end
    check("drain_timeout", 64'(expq.size()), 64'(0));
  endtask

  task automatic post_check();
    cycle();
    check("after_busy", 64'(s_busy), 64'(0));
    check("after_valid", 64'(s_valid), 64'(0));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    ch_enable = '0;
    out_ready = 1'b1;
    for (int i = 0; i < int'(N); i++) chq[i].delete();
    expq.delete();
    drive_fifos();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_chan", 64'(out_chan), 64'(0));
    check("rst_grant", 64'(grant), 64'(N - 1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_read", 64'(fifo_read), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl[6];
    int unsigned   n, exp_pops;
    logic [N-1:0]  en;
    word_t         w;

    tbl[0] = '{en: 4'b1111, ne: 4'b0001, words: 3, first: 2'd0, cyc: 5};
    tbl[1] = '{en: 4'b1111, ne: 4'b0100, words: 1, first: 2'd2, cyc: 3};
    tbl[2] = '{en: 4'b1010, ne: 4'b1111, words: 2, first: 2'd1, cyc: 0};
    tbl[3] = '{en: 4'b1100, ne: 4'b0111, words: 2, first: 2'd2, cyc: 0};
    tbl[4] = '{en: 4'b1111, ne: 4'b1000, words: 4, first: 2'd3, cyc: 6};
    tbl[5] = '{en: 4'b0001, ne: 4'b1111, words: 5, first: 2'd0, cyc: 8};

    ready_mode = 0;
    reset      = 1'b1;
    out_ready  = 1'b1;
    ch_enable  = '0;
    drive_fifos();

    // First-grant order, fill latency and drain timing
    for (int t = 0; t < 6; t++) begin
      do_reset();
      ready_mode = 0;
      ch_enable  = tbl[t].en;
      for (int unsigned i = 0; i < N; i++) if (tbl[t].ne[i]) load(i, tbl[t].words);
      build_exp(tbl[t].en, N - 1);
      exp_pops = expq.size();
      pops = 0;
      cycle();
      check("c0_valid", 64'(s_valid), 64'(0));
      check("c0_read", 64'(s_rd), 64'(0));
      cycle();
      check("c1_read", 64'(s_rd), 64'(N'(1) << tbl[t].first));
      cycle();
      check("c2_valid", 64'(s_valid), 64'(1));
      check("c2_chan", 64'(s_chan), 64'(tbl[t].first));
      drain(n);
      if (tbl[t].cyc != 0) check("drain_cycles", 64'(n + 3), 64'(tbl[t].cyc));
      check("pop_count", 64'(pops), 64'(exp_pops));
      post_check();
    end

    // Four channels x 6 words: 4-word bursts, one IDLE cycle per grant switch
    do_reset();
    ready_mode = 0;
    ch_enable  = '1;
    for (int unsigned i = 0; i < N; i++) load(i, 6);
    build_exp('1, N - 1);
    pops = 0;
    drain(n);
    check("full_cycles", 64'(n), 64'(36));
    check("full_pops", 64'(pops), 64'(24));
    post_check();

    // Same load with out_ready toggling every cycle
    do_reset();
    ready_mode = 1;
    ch_enable  = '1;
    for (int unsigned i = 0; i < N; i++) load(i, 6);
    build_exp('1, N - 1);
    pops = 0;
    drain(n);
    check("toggle_pops", 64'(pops), 64'(24));
    post_check();

    // Only odd channels enabled
    do_reset();
    ready_mode = 2;
    ch_enable  = 4'b1010;
    for (int unsigned i = 0; i < N; i++) load(i, 6);
    build_exp(4'b1010, N - 1);
    drain(n);
    post_check();
    check("odd_ch0_left", 64'(chq[0].size()), 64'(6));
    check("odd_ch2_left", 64'(chq[2].size()), 64'(6));

    // Enable of the granted channel dropped after two pops
    do_reset();
    ready_mode = 0;
    ch_enable  = '1;
    load(1, 6);
    load(2, 3);
    load(3, 3);
    w.ch = 2'd1; w.d = chq[1][0]; expq.push_back(w);
    w.ch = 2'd1; w.d = chq[1][1]; expq.push_back(w);
    cycle();
    cycle();
    check("en_rd1", 64'(s_rd), 64'(4'b0010));
    cycle();
    check("en_rd2", 64'(s_rd), 64'(4'b0010));
    ch_enable = 4'b1101;
    build_exp(4'b1101, 1);
    cycle();
    check("en_drop_rd", 64'(s_rd), 64'(0));
    check("en_drop_valid", 64'(s_valid), 64'(1));
    check("en_drop_chan", 64'(s_chan), 64'(1));
    drain(n);
    post_check();
    check("en_ch1_left", 64'(chq[1].size()), 64'(4));

    // Reset in the middle of a burst with a word held in the output register
    do_reset();
    ready_mode = 0;
    ch_enable  = '1;
    for (int unsigned i = 0; i < N; i++) load(i, 6);
    build_exp('1, N - 1);
    for (int k = 0; k < 4; k++) cycle();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_read", 64'(fifo_read), 64'(0));
    check("mid_rst_held", 64'(out_valid), 64'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_grant", 64'(grant), 64'(N - 1));
    check("mid_rst_read2", 64'(fifo_read), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_ch0_left", 64'(chq[0].size()), 64'(3));
    expq.delete();
    build_exp('1, N - 1);
    cycle();
    cycle();
    check("mid_rst_first", 64'(s_rd), 64'(4'b0001));
    drain(n);
    post_check();

    // Randomized loads, enables and backpressure
    for (int it = 0; it < 8; it++) begin
      do_reset();
      ready_mode = (it % 2 == 0) ? 2 : 1;
      en         = N'($urandom);
      ch_enable  = en;
      for (int unsigned i = 0; i < N; i++) load(i, $urandom_range(0, 9));
      build_exp(en, N - 1);
      exp_pops = expq.size();
      pops = 0;
      drain(n);
      post_check();
      check("rand_pops", 64'(pops), 64'(exp_pops));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
